// File: rtl/mem_seq.sv
// Byte-serial load/store sequencer: splits a 1/2/4-byte access into single-byte
// transactions on a handshake bus and assembles little-endian load results.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for i_start; validates and latches the request
// XFER  | one byte per ack on the bus, counter selects the byte lane
// FIN   | one-cycle o_done, load result already visible on o_rdata
module mem_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_insize,
  input  logic        i_insign,
  input  logic [2:0]  i_outsize,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  input  logic        i_bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_store;
  logic        r_insign;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_in_nz;
  logic        w_out_nz;
  logic [2:0]  w_req_size;
  logic        w_size_ok;
  logic        w_req_valid;
  logic        w_accept;
  logic        w_reject;
  logic [1:0]  w_last_idx;
  logic        w_last;
  logic        w_xfer_ack;
  logic [7:0]  w_wbyte;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_ext;

  // Request decode: exactly one direction, legal size, naturally aligned.
  assign w_in_nz    = |i_insize;
  assign w_out_nz   = |i_outsize;
  assign w_req_size = w_out_nz ? i_outsize : i_insize;

  always_comb begin
    w_size_ok = 1'b0;
    case (w_req_size)
      3'd1:    w_size_ok = 1'b1;
      3'd2:    w_size_ok = ~i_addr[0];
      3'd4:    w_size_ok = ~(|i_addr[1:0]);
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_req_valid = (w_in_nz ^ w_out_nz) & w_size_ok;
  assign w_accept    = (r_state == IDLE) & i_start & w_req_valid;
  assign w_reject    = (r_state == IDLE) & i_start & (w_in_nz | w_out_nz) & ~w_req_valid;

  always_comb begin
    w_last_idx = 2'd3;
    case (r_size)
      3'd1:    w_last_idx = 2'd0;
      3'd2:    w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  assign w_last     = (r_cnt == w_last_idx);
  assign w_xfer_ack = (r_state == XFER) & i_bus_ack;

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt)
      2'd0: w_wbyte = r_wdata[7:0];
      2'd1: w_wbyte = r_wdata[15:8];
      2'd2: w_wbyte = r_wdata[23:16];
      2'd3: w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // Load buffer with the byte arriving this cycle merged in, so the final
  // byte can be folded into o_rdata on the same edge that enters FIN.
  always_comb begin
    w_buf_nxt = r_buf;
    case (r_cnt)
      2'd0: w_buf_nxt[7:0]   = i_bus_rdata;
      2'd1: w_buf_nxt[15:8]  = i_bus_rdata;
      2'd2: w_buf_nxt[23:16] = i_bus_rdata;
      2'd3: w_buf_nxt[31:24] = i_bus_rdata;
      default: w_buf_nxt = r_buf;
    endcase
  end

  always_comb begin
    w_ext = w_buf_nxt;
    case (r_size)
      3'd1:    w_ext = {{24{r_insign & w_buf_nxt[7]}}, w_buf_nxt[7:0]};
      3'd2:    w_ext = {{16{r_insign & w_buf_nxt[15]}}, w_buf_nxt[15:0]};
      default: w_ext = w_buf_nxt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus outputs are decoded from state so reset drops o_bus_req immediately.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = 32'd0;
    o_bus_wdata = 8'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        o_busy      = 1'b1;
        o_bus_req   = 1'b1;
        o_bus_we    = r_store;
        o_bus_addr  = r_addr + {30'd0, r_cnt};
        o_bus_wdata = r_store ? w_wbyte : 8'd0;
        if (i_bus_ack && w_last) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_size   <= 3'd0;
      r_store  <= 1'b0;
      r_insign <= 1'b0;
      r_cnt    <= 2'd0;
      r_buf    <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        r_size   <= w_req_size;
        r_store  <= w_out_nz;
        r_insign <= i_insign;
        r_cnt    <= 2'd0;
        r_buf    <= 32'd0;
      end else if (w_xfer_ack) begin
        if (!r_store) begin
          r_buf <= w_buf_nxt;
        end
        if (w_last) begin
          if (!r_store) begin
            r_rdata <= w_ext;
          end
        end else begin
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign o_err   = r_err;
  assign o_rdata = r_rdata;

endmodule
